// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the controller state enum and the BCD output width function.
package multiplier_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // One BCD digit per started group of three binary bits always suffices.
   function automatic int unsigned bcd_width(input int unsigned bin_w);
      return (bin_w / 3 + 1) * 4;
   endfunction

endpackage

// File: rtl/multiplier_bin2bcd.sv
// Combinational binary-to-packed-BCD converter (double-dabble).
// Digit 0 sits in bits [3:0]; unused upper digits read as zero.
module multiplier_bin2bcd
   import multiplier_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]              bin,
   output logic [bcd_width(W)-1:0]   bcd
);

   localparam int BW     = bcd_width(W);
   localparam int DIGITS = BW / 4;

   logic [W+BW-1:0] scratch;

   // Binary bits shift up into the BCD field; any digit >= 5 gets +3 first.
   always_comb begin
      scratch = '0;
      scratch[W-1:0] = bin;
      for (int i = 0; i < W; i++) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (scratch[W + 4*d +: 4] >= 4'd5) begin
               scratch[W + 4*d +: 4] = scratch[W + 4*d +: 4] + 4'd3;
            end
         end
         scratch = scratch << 1;
      end
      bcd = scratch[W +: BW];
   end

endmodule

// File: rtl/multiplier.sv
// Sequential N-bit unsigned shift-add multiplier with registered product and done flag.
// Optional BCD view of the product is built only when MULTIPLIER_BCD_EN is defined.
module multiplier
   import multiplier_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N-1:0]                a_in,
   input  logic [N-1:0]                b_in,
   input  logic                        start,
   output logic [2*N-1:0]              out,
   output logic                        finish,
   output logic [bcd_width(2*N)-1:0]   bcd
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state;
   logic             start_q;
   logic [2*N-1:0]   mcand;
   logic [N-1:0]     mplier;
   logic [2*N-1:0]   acc;
   logic [2*N-1:0]   acc_next;
   logic [CW-1:0]    cnt;

   assign acc_next = acc + (mplier[0] ? mcand : '0);

   // Product only reaches out on the final iteration, so partial sums stay hidden.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         start_q <= 1'b0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         out     <= '0;
         finish  <= 1'b0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (start && !start_q) begin
                  mcand  <= {{N{1'b0}}, a_in};
                  mplier <= b_in;
                  acc    <= '0;
                  cnt    <= '0;
                  finish <= 1'b0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  out    <= acc_next;
                  finish <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MULTIPLIER_BCD_EN
   multiplier_bin2bcd #(
      .W (2*N)
   ) u_bin2bcd (
      .bin (out),
      .bcd (bcd)
   );
`else
   assign bcd = '0;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (N=5): directed table, corner sequences and random ops.
// Expected products and BCD come from plain arithmetic in the bench.
module tb_multiplier;
   import multiplier_pkg::*;

   localparam int N  = 5;
   localparam int BW = bcd_width(2*N);

`ifdef MULTIPLIER_BCD_EN
   localparam bit BCD_EN = 1'b1;
`else
   localparam bit BCD_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     a_in;
   logic [N-1:0]     b_in;
   logic             start;
   logic [2*N-1:0]   out;
   logic             finish;
   logic [BW-1:0]    bcd;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] prod;
      logic [BW-1:0]  bcd_val;
   } vec_t;

   vec_t vecs[5];

   multiplier #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .a_in   (a_in),
      .b_in   (b_in),
      .start  (start),
      .out    (out),
      .finish (finish),
      .bcd    (bcd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [BW-1:0] bcd_ref(input int unsigned value);
      logic [BW-1:0] r;
      int unsigned   v;
      r = '0;
      v = value;
      for (int d = 0; d < BW/4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return BCD_EN ? r : '0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, required, required);
      end
   endtask

   // Launch one operation and follow it to completion with a bounded wait.
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2*N-1:0] exp_out, input logic [BW-1:0] exp_bcd,
                                input bit hold, input bit scramble, input string tag);
      logic [2*N-1:0] prev_out;
      int             latency;
      bit             partial_seen;
      @(negedge clk);
      a_in = a;
      b_in = b;
      start = 1'b1;
      prev_out = out;
      latency = 0;
      partial_seen = 1'b0;
      @(posedge clk); #1;
      checkOutput({tag, " finish_cleared_at_accept"}, 32'(finish), 32'd0);
      for (int e = 1; e <= 20 && latency == 0; e++) begin
         @(negedge clk);
         if (scramble && e == 2) begin
            a_in = ~a;
            b_in = ~b;
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (finish) latency = e;
         else if (out !== prev_out) partial_seen = 1'b1;
      end
      checkOutput({tag, " latency"}, 32'(latency), 32'(N));
      checkOutput({tag, " no_partial_out"}, 32'(partial_seen), 32'd0);
      checkOutput({tag, " out"}, 32'(out), 32'(exp_out));
      checkOutput({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [N-1:0]   ra;
      logic [N-1:0]   rb;
      logic [2*N-1:0] rp;
      int             disturbed;

      vecs[0] = '{5'd26, 5'd30, 10'd780, 16'h0780};
      vecs[1] = '{5'd13, 5'd13, 10'd169, 16'h0169};
      vecs[2] = '{5'd31, 5'd31, 10'd961, 16'h0961};
      vecs[3] = '{5'd0,  5'd17, 10'd0,   16'h0000};
      vecs[4] = '{5'd1,  5'd31, 10'd31,  16'h0031};

      reset = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      @(posedge clk); #1;
      checkOutput("reset out", 32'(out), 32'd0);
      checkOutput("reset finish", 32'(finish), 32'd0);
      checkOutput("reset bcd", 32'(bcd), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] directed table");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod,
                       BCD_EN ? vecs[i].bcd_val : '0, 1'b0, 1'b0, $sformatf("vec%0d", i));
      end

      $display("[TB] start held high after completion");
      applyStimulus(5'd7, 5'd9, 10'd63, bcd_ref(63), 1'b1, 1'b0, "hold");
      disturbed = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (!finish || out !== 10'd63) disturbed++;
      end
      checkOutput("hold no_retrigger", 32'(disturbed), 32'd0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;

      $display("[TB] operands changed mid-operation");
      applyStimulus(5'd19, 5'd22, 10'd418, bcd_ref(418), 1'b0, 1'b1, "scramble");

      $display("[TB] reset on third busy edge");
      @(negedge clk);
      a_in = 5'd9;
      b_in = 5'd7;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midreset out", 32'(out), 32'd0);
      checkOutput("midreset finish", 32'(finish), 32'd0);
      checkOutput("midreset bcd", 32'(bcd), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      disturbed = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (finish || out !== '0) disturbed++;
      end
      checkOutput("midreset stays_idle", 32'(disturbed), 32'd0);
      applyStimulus(5'd9, 5'd7, 10'd63, bcd_ref(63), 1'b0, 1'b0, "after_reset");

      $display("[TB] random operations");
      for (int r = 0; r < 30; r++) begin
         ra = N'($urandom_range(0, (1 << N) - 1));
         rb = N'($urandom_range(0, (1 << N) - 1));
         rp = (2*N)'(int'(ra) * int'(rb));
         applyStimulus(ra, rb, rp, bcd_ref(int'(ra) * int'(rb)), 1'b0, 1'b0,
                       $sformatf("rand%0d_%0dx%0d", r, ra, rb));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (legal N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a_in  input  N  unsigned multiplicand.
REQ-005 SHALL have port b_in  input  N  unsigned multiplier.
REQ-006 SHALL have port start  input  1  level request; a 0->1 transition launches an operation.
REQ-007 SHALL have port out  output  2N  registered unsigned product.
REQ-008 SHALL have port finish  output  1  registered done flag.
REQ-009 SHALL have port bcd  output  BW = ((2N)/3+1)*4 (integer division)  packed BCD of out, digit 0 in bits [3:0].

Function
REQ-010 SHALL register start each cycle (start_q); an accept event is start=1 and start_q=0 while in IDLE.
REQ-011 SHALL implement two states, IDLE and BUSY; IDLE->BUSY on accept; BUSY->IDLE when the iteration counter reaches N.
REQ-012 SHALL, on the accept edge, latch a_in and b_in internally, clear accumulator and counter, and clear finish.
REQ-013 SHALL perform one shift-add iteration per BUSY cycle: if current multiplier bit is 1, add the shifted multiplicand into a 2N-bit accumulator; advance one bit.
REQ-014 SHALL, on the Nth BUSY edge after the accept edge, load out with the full product and set finish=1, in the same edge as BUSY->IDLE.
REQ-015 SHALL hold out and finish stable in IDLE until the next accept; out SHALL NOT show partial products during BUSY.
REQ-016 SHALL ignore a_in, b_in and start changes during BUSY; deassertion of start does not abort.
REQ-017 SHALL NOT re-trigger while start is held high; start must be seen low for at least one edge before a new accept.
REQ-018 SHALL produce an exact product: no overflow is possible for 2N-bit out.
REQ-019 SHALL derive bcd combinationally from out (double-dabble), zero-padding the unused upper digits.

Reset
REQ-020 SHALL, when reset=1 at a clock edge, force IDLE, out=0, finish=0, start_q=0, and clear counter, accumulator and latched operands; hence bcd=0.
REQ-021 SHALL give reset priority over accept and over BUSY iterations; a reset mid-operation discards the operation.

Configuration
REQ-022 SHALL honour macro MULTIPLIER_BCD_EN: when defined, bcd follows REQ-019; when undefined, the BCD converter is omitted, bcd is tied to 0 and port widths are unchanged.

Structure
REQ-023 SHALL place the state enum typedef (IDLE, BUSY) and a BCD-width constant function in a shared package multiplier_pkg.
REQ-024 SHALL implement the binary-to-BCD converter as one sub-module, multiplier_bin2bcd, parameterised by input width.

Verification
REQ-025 SHALL cover: N=5, reset 1 cycle, a_in=26, b_in=30, start rises -> finish=1 exactly 5 edges after accept, out=780, bcd=16'h0780.
REQ-026 SHALL cover: N=5, after start low, a_in=13, b_in=13, start rises -> finish cleared at accept, then out=169, bcd=16'h0169 after 5 edges.
REQ-027 SHALL cover: N=5, a_in=31, b_in=31 -> out=961, bcd=16'h0961; and a_in=0, b_in=17 -> out=0, finish=1.
REQ-028 SHALL cover: start held high for 20 cycles after completion -> exactly one operation; a_in/b_in changed mid-BUSY -> product of latched values.
REQ-029 SHALL cover: reset asserted on the 3rd BUSY edge -> out=0, finish=0, IDLE; the next start rise completes normally.
REQ-030 SHALL cover: build without MULTIPLIER_BCD_EN -> bcd=0 for 26*30 while out=780.
